// File: rtl/multi_rate_clkgen.sv
`default_nettype none
// ============================================================================
// Module : multi_rate_clkgen
// Brief  : NUM_CH runtime-programmable low-rate square-wave and tick
//          generators with glitch-free half-period reconfiguration.
// Rev    : 1.0  initial release
// ============================================================================
module multi_rate_clkgen #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 24,
    parameter int DEFAULT_HALF = 499999,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100MHz,
    input  logic              rst_100MHz,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] tick_rise
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] pend_vec;

    // Out-of-range channel indices are always ready and silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        if ({1'b0, cfg_ch} < NUM_CH_L) begin
            cfg_ready = ~pend_vec[cfg_ch];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] half_q, half_d;
        logic [CNT_W-1:0] pval_q, pval_d;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             rise_q, rise_d;
        logic             accept;
        logic             wrap;

        assign accept = cfg_valid && !pend_q && (cfg_ch == CH_W'(c));
        assign wrap   = (cnt_q >= half_q);

        always_comb begin
            cnt_d  = cnt_q;
            half_d = half_q;
            pval_d = pval_q;
            pend_d = pend_q;
            clk_d  = clk_q;
            tick_d = 1'b0;
            rise_d = 1'b0;
            if (sync_restart || !ch_en[c]) begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (pend_q) begin
                    half_d = pval_q;
                    pend_d = 1'b0;
                end
            end else if (wrap) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                rise_d = ~clk_q;
                // New half-period only takes effect on a phase boundary.
                if (pend_q) begin
                    half_d = pval_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Accept only happens with pend_q low, so it never races an apply.
            if (accept) begin
                pval_d = cfg_half;
                pend_d = 1'b1;
            end
        end

        always_ff @(posedge clk_100MHz) begin
            if (rst_100MHz) begin
                cnt_q  <= '0;
                half_q <= CNT_W'(DEFAULT_HALF);
                pval_q <= '0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                half_q <= half_d;
                pval_q <= pval_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
                rise_q <= rise_d;
            end
        end

        assign pend_vec[c]  = pend_q;
        assign clk_out[c]   = clk_q;
        assign tick[c]      = tick_q;
        assign tick_rise[c] = rise_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_rate_clkgen.sv
`default_nettype none
// ============================================================================
// Module : tb_multi_rate_clkgen
// Brief  : Directed self-checking bench for multi_rate_clkgen.
// Rev    : 1.0  initial release
// ============================================================================
module tb_multi_rate_clkgen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 24;
    localparam int DEF_H  = 49;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_restart;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] tick_rise;

    int checks   = 0;
    int failures = 0;

    multi_rate_clkgen #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEF_H)
    ) dut (
        .clk_100MHz   (clk),
        .rst_100MHz   (rst),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_half     (cfg_half),
        .clk_out      (clk_out),
        .tick         (tick),
        .tick_rise    (tick_rise)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {clk_out, tick, tick_rise} k edges into a fresh phase with half h.
    function automatic logic [2:0] model(input int k, input int h);
        logic c;
        logic t;
        c = ((k / (h + 1)) % 2) == 1;
        t = (k % (h + 1)) == 0;
        return {c, t, t & c};
    endfunction

    function automatic logic [2:0] obs3(input int c);
        return {clk_out[c], tick[c], tick_rise[c]};
    endfunction

    initial begin
        logic [2:0] e3;
        logic [3:0] ec;
        logic [3:0] et;
        logic [3:0] er;

        rst          = 1'b1;
        ch_en        = '0;
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        cfg_ch       = '0;
        cfg_half     = '0;
        step();
        step();
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_tick_rise", 32'(tick_rise), 32'h0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);

        // Default half-period on ch0: rise at edge 50, fall at edge 100.
        rst   = 1'b0;
        ch_en = 4'b0001;
        for (int k = 1; k <= 100; k++) begin
            step();
            chk("ch0_default", 32'(obs3(0)), 32'(model(k, DEF_H)));
        end

        // Program disabled ch1 with half=0: applied one cycle after acceptance.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_half  = 24'd0;
        #1;
        chk("ch1_ready_before", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        #1;
        chk("ch1_ready_pending", 32'(cfg_ready), 32'h0);
        step();
        chk("ch1_ready_applied", 32'(cfg_ready), 32'h1);
        ch_en = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("ch1_half0", 32'(obs3(1)), 32'(model(k, 0)));
        end

        // ch2 at half=9, reprogrammed to half=3 while cnt=4.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_half  = 24'd9;
        step();
        cfg_valid = 1'b0;
        step();
        ch_en = 4'b0111;
        for (int k = 1; k <= 22; k++) begin
            step();
            e3[2] = ((k >= 10) && (k <= 13)) || ((k >= 18) && (k <= 21));
            e3[1] = (k == 10) || (k == 14) || (k == 18) || (k == 22);
            e3[0] = (k == 10) || (k == 18);
            chk("ch2_reconfig", 32'(obs3(2)), 32'(e3));
            case (k)
                4: begin
                    cfg_valid = 1'b1;
                    cfg_ch    = 2'd2;
                    cfg_half  = 24'd3;
                    #1;
                    chk("ch2_ready_accept", 32'(cfg_ready), 32'h1);
                end
                5: begin
                    cfg_valid = 1'b0;
                    #1;
                    chk("ch2_ready_low5", 32'(cfg_ready), 32'h0);
                end
                6: begin
                    cfg_valid = 1'b1;
                    cfg_half  = 24'd7;
                    #1;
                    chk("ch2_second_cfg_ready", 32'(cfg_ready), 32'h0);
                end
                7: begin
                    cfg_ch   = 2'd3;
                    cfg_half = 24'd5;
                    #1;
                    chk("ch3_cfg_ready", 32'(cfg_ready), 32'h1);
                end
                8: begin
                    cfg_valid = 1'b0;
                    cfg_ch    = 2'd2;
                    #1;
                    chk("ch2_ready_low8", 32'(cfg_ready), 32'h0);
                end
                10: chk("ch2_ready_after_apply", 32'(cfg_ready), 32'h1);
                default: ;
            endcase
        end

        // Re-phase everything, then queue new halves and restart again.
        sync_restart = 1'b1;
        ch_en        = 4'b1111;
        step();
        sync_restart = 1'b0;
        chk("restart0_clk_out", 32'(clk_out), 32'h0);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_half  = 24'd2;
        step();
        cfg_ch    = 2'd3;
        cfg_half  = 24'd8;
        step();
        cfg_ch    = 2'd2;
        cfg_half  = 24'd6;
        step();
        cfg_ch    = 2'd1;
        cfg_half  = 24'd4;
        step();
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        #1;
        chk("ch0_pending_pre_restart", 32'(cfg_ready), 32'h0);
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        chk("restart_clk_out", 32'(clk_out), 32'h0);
        chk("restart_tick", 32'(tick), 32'h0);
        chk("restart_ch0_applied", 32'(cfg_ready), 32'h1);
        for (int k = 1; k <= 22; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                e3    = model(k, 2 + 2 * c);
                ec[c] = e3[2];
                et[c] = e3[1];
                er[c] = e3[0];
            end
            chk("restart_clk_out_k", 32'(clk_out), 32'(ec));
            chk("restart_tick_k", 32'(tick), 32'(et));
            chk("restart_rise_k", 32'(tick_rise), 32'(er));
        end

        // ch0 is mid-high-phase here; disable then re-enable.
        ch_en[0] = 1'b0;
        step();
        chk("ch0_disabled", 32'(obs3(0)), 32'h0);
        ch_en[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("ch0_reenable", 32'(obs3(0)), 32'(model(k, 2)));
        end

        // Reset mid-operation brings back the default half on every channel.
        rst = 1'b1;
        step();
        chk("rst2_clk_out", 32'(clk_out), 32'h0);
        chk("rst2_tick", 32'(tick), 32'h0);
        chk("rst2_cfg_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            ec = (k == 50) ? 4'hF : 4'h0;
            chk("rst2_default_clk", 32'(clk_out), 32'(ec));
            chk("rst2_default_tick", 32'(tick), 32'(ec));
            chk("rst2_default_rise", 32'(tick_rise), 32'(ec));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
